// File: rtl/llc_pipe_ctrl_pkg.sv
// Shared LLC pipeline constants: state encoding and parameter limits.
// Counter widths are sized from the limits so every legal setting fits.
package llc_pipe_ctrl_pkg;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned TMO_MIN    = 1;
  localparam int unsigned TMO_MAX    = 65535;

  localparam int unsigned RD_CNT_W  = $clog2(RD_LAT_MAX);
  localparam int unsigned TMO_CNT_W = $clog2(TMO_MAX + 1);

  typedef enum logic [2:0] {
    StDecode  = 3'd0,
    StReadSet = 3'd1,
    StReadMem = 3'd2,
    StLookup  = 3'd3,
    StProcess = 3'd4,
    StUpdate  = 3'd5
  } pipe_state_e;

endpackage

// File: rtl/llc_pipe_ctrl_if.sv
// Request/accept handshakes and stage-enable outputs of the LLC pipeline controller.
// The slave modport is the controller's view; master is the environment's view.
interface llc_pipe_ctrl_if #(
  parameter int unsigned NUM_CH = 4
);
  localparam int unsigned SEL_W = $clog2(NUM_CH);

  logic              rst_tb_valid;
  logic              rsp_valid;
  logic [NUM_CH-1:0] ch_valid;
  logic              stall;
  logic              process_done;
  logic              resume;
  logic              done_ready;

  logic              rst_tb_ready;
  logic              rsp_ready;
  logic [NUM_CH-1:0] ch_ready;
  logic [SEL_W-1:0]  sel;
  logic              rd_set_en;
  logic              rd_mem_en;
  logic              lookup_en;
  logic              process_en;
  logic              update_en;
  logic              rst_tb_done_valid;
  logic              tmo_err;
  logic              busy;

  modport master (
    output rst_tb_valid, rsp_valid, ch_valid, stall, process_done, resume, done_ready,
    input  rst_tb_ready, rsp_ready, ch_ready, sel, rd_set_en, rd_mem_en, lookup_en,
           process_en, update_en, rst_tb_done_valid, tmo_err, busy
  );

  modport slave (
    input  rst_tb_valid, rsp_valid, ch_valid, stall, process_done, resume, done_ready,
    output rst_tb_ready, rsp_ready, ch_ready, sel, rd_set_en, rd_mem_en, lookup_en,
           process_en, update_en, rst_tb_done_valid, tmo_err, busy
  );

endinterface

// File: rtl/llc_rr_arbiter.sv
// Round-robin arbiter: searches from last+1 (wrapping) for the first requester.
// A high mask suppresses every request.
module llc_rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic              mask,
  input  logic [IDX_W-1:0]  last,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  index
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  always_comb begin
    grant    = '0;
    index    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand     = (32'(last) + i) % NUM_CH;
      cand_idx = IDX_W'(cand);
      if (!found && !mask && req[cand_idx]) begin
        grant[cand_idx] = 1'b1;
        index           = cand_idx;
        found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/llc_pipe_ctrl.sv
// LLC pipeline sequencer: arbitrates reset/flush, response and channel requests in DECODE,
// then steps READ_SET, READ_MEM, LOOKUP, PROCESS (with timeout) and UPDATE.
module llc_pipe_ctrl
  import llc_pipe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned TMO    = 255
) (
  input  logic           clk,
  input  logic           rst,
  llc_pipe_ctrl_if.slave bus
);

  localparam int unsigned            SEL_W    = $clog2(NUM_CH);
  localparam logic [RD_CNT_W-1:0]    RD_LOAD  = RD_CNT_W'(RD_LAT - 1);
  localparam logic [TMO_CNT_W-1:0]   TMO_LAST = TMO_CNT_W'(TMO - 1);

  if (NUM_CH < 2 || NUM_CH > 8 || RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX ||
      TMO < TMO_MIN || TMO > TMO_MAX) begin : g_bad_param
    $error("llc_pipe_ctrl: parameter out of range");
  end

  pipe_state_e          state_q, state_d;
  logic [SEL_W-1:0]     last_q, last_d;
  logic [RD_CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                 tmo_err_q, tmo_err_d;
  logic [NUM_CH-1:0]    arb_grant;
  logic [SEL_W-1:0]     arb_index;

  llc_rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .req  (bus.ch_valid),
    .mask (bus.stall),
    .last (last_q),
    .grant(arb_grant),
    .index(arb_index)
  );

  always_comb begin
    state_d          = state_q;
    last_d           = last_q;
    rd_cnt_d         = rd_cnt_q;
    tmo_cnt_d        = tmo_cnt_q;
    tmo_err_d        = tmo_err_q;
    bus.rst_tb_ready = 1'b0;
    bus.rsp_ready    = 1'b0;
    bus.ch_ready     = '0;
    unique case (state_q)
      StDecode: begin
        // Readies are combinational, so hold them off while reset is asserted.
        if (rst) begin
          if (bus.rst_tb_valid) begin
            bus.rst_tb_ready = 1'b1;
            state_d          = StReadSet;
          end else if (bus.rsp_valid) begin
            bus.rsp_ready = 1'b1;
            state_d       = StReadSet;
          end else if (|arb_grant) begin
            bus.ch_ready = arb_grant;
            last_d       = arb_index;
            state_d      = StReadSet;
          end
        end
      end
      StReadSet: begin
        rd_cnt_d = RD_LOAD;
        state_d  = StReadMem;
      end
      StReadMem: begin
        if (rd_cnt_q == '0) begin
          state_d = StLookup;
        end else begin
          rd_cnt_d = rd_cnt_q - 1'b1;
        end
      end
      StLookup: begin
        tmo_cnt_d = '0;
        state_d   = StProcess;
      end
      StProcess: begin
        // A completion in the timeout cycle wins: no error is flagged.
        if (bus.process_done) begin
          tmo_cnt_d = '0;
          state_d   = StUpdate;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_cnt_d = '0;
          tmo_err_d = 1'b1;
          state_d   = StUpdate;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      StUpdate: begin
        if (!bus.resume || bus.done_ready) begin
          state_d = StDecode;
        end
      end
      default: state_d = StDecode;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StDecode;
      last_q    <= SEL_W'(NUM_CH - 1);
      rd_cnt_q  <= '0;
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      rd_cnt_q  <= rd_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign bus.rd_set_en         = (state_q == StReadSet);
  assign bus.rd_mem_en         = (state_q == StReadMem);
  assign bus.lookup_en         = (state_q == StLookup);
  assign bus.process_en        = (state_q == StLookup) || (state_q == StProcess);
  assign bus.update_en         = (state_q == StUpdate);
  assign bus.rst_tb_done_valid = (state_q == StUpdate) && bus.resume;
  assign bus.tmo_err           = tmo_err_q;
  assign bus.busy              = (state_q != StDecode);
  assign bus.sel               = rst ? last_q : '0;

endmodule

// File: tb/tb_llc_pipe_ctrl.sv
// Self-checking bench for llc_pipe_ctrl (NUM_CH=4, RD_LAT=3, TMO=10).
// Expected grants are queued when stimulus is driven and checked by a grant monitor.
`timescale 1ns/1ps
module tb_llc_pipe_ctrl;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned RD_LAT = 3;
  localparam int unsigned TMO    = 10;
  localparam int KIND_RST = 0;
  localparam int KIND_RSP = 1;
  localparam int KIND_CH  = 2;

  typedef struct {
    int kind;
    int idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  llc_pipe_ctrl_if #(.NUM_CH(NUM_CH)) bus ();

  llc_pipe_ctrl #(
    .NUM_CH(NUM_CH),
    .RD_LAT(RD_LAT),
    .TMO   (TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  exp_t mon_got;
  exp_t mon_exp;

  // Grant monitor: every ready pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst && (bus.rst_tb_ready || bus.rsp_ready || (|bus.ch_ready))) begin
      mon_got.kind = bus.rst_tb_ready ? KIND_RST : (bus.rsp_ready ? KIND_RSP : KIND_CH);
      mon_got.idx  = 0;
      for (int i = 0; i < NUM_CH; i++) if (bus.ch_ready[i]) mon_got.idx = i;
      n_checks++;
      if ($countones({bus.rst_tb_ready, bus.rsp_ready, bus.ch_ready}) !== 1) begin
        n_fail++;
        $display("FAIL grant_onehot: got rst_tb=%b rsp=%b ch=%b, required exactly one",
                 bus.rst_tb_ready, bus.rsp_ready, bus.ch_ready);
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL grant_unexpected: got kind %0d idx %0d, required no grant",
                 mon_got.kind, mon_got.idx);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got.kind !== mon_exp.kind || mon_got.idx !== mon_exp.idx) begin
          n_fail++;
          $display("FAIL grant_order: got kind %0d idx %0d, required kind %0d idx %0d",
                   mon_got.kind, mon_got.idx, mon_exp.kind, mon_exp.idx);
        end
      end
    end
  end

  task automatic push_exp(input int kind, input int idx);
    exp_t e;
    e.kind = kind;
    e.idx  = idx;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (bus.busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: busy stuck at %b, required 0", tag, bus.busy);
    end
  endtask

  task automatic wait_drained(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d grants outstanding, required 0", tag, exp_q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst              = 1'b0;
    bus.rst_tb_valid = 1'b1;
    bus.rsp_valid    = 1'b1;
    bus.ch_valid     = 4'hf;
    bus.stall        = 1'b0;
    bus.process_done = 1'b0;
    bus.resume       = 1'b1;
    bus.done_ready   = 1'b0;
    #22;
    n_checks++;
    if ({bus.rst_tb_ready, bus.rsp_ready, bus.ch_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, required 0",
               {bus.rst_tb_ready, bus.rsp_ready, bus.ch_ready});
    end
    n_checks++;
    if ({bus.rd_set_en, bus.rd_mem_en, bus.lookup_en, bus.process_en, bus.update_en} !== 5'b0)
    begin
      n_fail++;
      $display("FAIL reset_enables: got %b, required 0",
               {bus.rd_set_en, bus.rd_mem_en, bus.lookup_en, bus.process_en, bus.update_en});
    end
    n_checks++;
    if ({bus.sel, bus.busy, bus.tmo_err, bus.rst_tb_done_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_status: got sel=%0d busy=%b tmo=%b done=%b, required all 0",
               bus.sel, bus.busy, bus.tmo_err, bus.rst_tb_done_valid);
    end
    bus.rst_tb_valid = 1'b0;
    bus.rsp_valid    = 1'b0;
    bus.ch_valid     = '0;
    bus.process_done = 1'b1;
    bus.resume       = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.sel !== 2'd3 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got sel=%0d busy=%b, required sel=3 busy=0",
               bus.sel, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    @(posedge clk);
    #1;
    push_exp(KIND_CH, 0);
    push_exp(KIND_CH, 1);
    push_exp(KIND_CH, 2);
    push_exp(KIND_CH, 3);
    push_exp(KIND_CH, 0);
    bus.ch_valid = 4'hf;
    wait_drained("rr");
    bus.ch_valid = '0;
    wait_idle("rr");
    n_checks++;
    if (bus.sel !== 2'd0) begin
      n_fail++;
      $display("FAIL rr_sel: got %0d, required 0", bus.sel);
    end
  endtask

  task automatic test_priority();
    int  k;
    bit  sel_seen;
    @(posedge clk);
    #1;
    push_exp(KIND_RST, 0);
    push_exp(KIND_RSP, 0);
    push_exp(KIND_CH, 2);
    bus.rst_tb_valid = 1'b1;
    bus.rsp_valid    = 1'b1;
    bus.ch_valid     = 4'b0100;
    @(negedge clk);
    n_checks++;
    if ({bus.rst_tb_ready, bus.rsp_ready, bus.ch_ready} !== 6'b100000) begin
      n_fail++;
      $display("FAIL prio_first: got %b, required 100000",
               {bus.rst_tb_ready, bus.rsp_ready, bus.ch_ready});
    end
    k        = 0;
    sel_seen = 1'b0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
      if (exp_q.size() == 2) bus.rst_tb_valid = 1'b0;
      if (exp_q.size() == 1) begin
        bus.rsp_valid = 1'b0;
        if (!sel_seen) begin
          sel_seen = 1'b1;
          n_checks++;
          if (bus.sel !== 2'd0) begin
            n_fail++;
            $display("FAIL prio_sel_kept: got %0d, required 0", bus.sel);
          end
        end
      end
    end
    bus.ch_valid = '0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL prio_drain: %0d grants outstanding, required 0", exp_q.size());
    end
    wait_idle("prio");
    n_checks++;
    if (bus.sel !== 2'd2) begin
      n_fail++;
      $display("FAIL prio_sel_ch: got %0d, required 2", bus.sel);
    end
  endtask

  task automatic test_rd_latency();
    int start, lk, mem_n, set_n;
    start = -1;
    lk    = -1;
    mem_n = 0;
    set_n = 0;
    @(posedge clk);
    #1;
    push_exp(KIND_CH, 1);
    bus.ch_valid = 4'b0010;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (start < 0 && bus.ch_ready[1]) start = k;
      else if (start >= 0) bus.ch_valid = '0;
      if (bus.rd_mem_en) mem_n++;
      if (bus.rd_set_en) set_n++;
      if (bus.lookup_en && lk < 0) lk = k;
      if (bus.update_en) break;
    end
    bus.ch_valid = '0;
    n_checks++;
    if (start < 0 || lk - start != 5) begin
      n_fail++;
      $display("FAIL rdlat_span: got %0d cycles, required 5", lk - start);
    end
    n_checks++;
    if (mem_n != 3) begin
      n_fail++;
      $display("FAIL rdlat_mem: got %0d cycles, required 3", mem_n);
    end
    n_checks++;
    if (set_n != 1) begin
      n_fail++;
      $display("FAIL rdlat_set: got %0d cycles, required 1", set_n);
    end
    wait_idle("rdlat");
  endtask

  // Finish exactly on the TMO-th PROCESS cycle (done_at=TMO-1) or never (done_at<0).
  task automatic run_process(input string tag, input int ch, input int done_at,
                             input bit exp_err);
    int p, u;
    p = -1;
    u = -1;
    bus.process_done = 1'b0;
    @(posedge clk);
    #1;
    push_exp(KIND_CH, ch);
    bus.ch_valid = 4'(1 << ch);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.busy) bus.ch_valid = '0;
      if (p < 0 && bus.process_en && !bus.lookup_en) p = k;
      if (p >= 0 && done_at >= 0 && k == p + done_at) bus.process_done = 1'b1;
      if (bus.update_en) begin
        u = k;
        break;
      end
    end
    bus.ch_valid     = '0;
    bus.process_done = 1'b1;
    n_checks++;
    if (p < 0 || u - p != int'(TMO)) begin
      n_fail++;
      $display("FAIL %s_span: got %0d cycles in PROCESS, required %0d", tag, u - p, TMO);
    end
    n_checks++;
    if (bus.tmo_err !== exp_err) begin
      n_fail++;
      $display("FAIL %s_err: got tmo_err=%b, required %b", tag, bus.tmo_err, exp_err);
    end
    wait_idle(tag);
  endtask

  task automatic test_done_at_timeout();
    do_reset();
    run_process("tmo_tie", 0, int'(TMO) - 1, 1'b0);
  endtask

  task automatic test_timeout();
    run_process("tmo", 2, -1, 1'b1);
    n_checks++;
    if (bus.tmo_err !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_sticky: got %b, required 1", bus.tmo_err);
    end
  endtask

  task automatic test_resume();
    int k;
    bus.resume     = 1'b1;
    bus.done_ready = 1'b0;
    @(posedge clk);
    #1;
    push_exp(KIND_CH, 3);
    bus.ch_valid = 4'b1000;
    k = 0;
    @(negedge clk);
    while (!bus.update_en && k < 40) begin
      if (bus.busy) bus.ch_valid = '0;
      @(negedge clk);
      k++;
    end
    bus.ch_valid = '0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.update_en !== 1'b1 || bus.rst_tb_done_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL resume_hold%0d: got update=%b done_valid=%b, required 1 1",
                 i, bus.update_en, bus.rst_tb_done_valid);
      end
      @(posedge clk);
      #1;
    end
    bus.done_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.update_en !== 1'b1 || bus.rst_tb_done_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL resume_accept: got update=%b done_valid=%b, required 1 1",
               bus.update_en, bus.rst_tb_done_valid);
    end
    @(posedge clk);
    #1;
    bus.done_ready = 1'b0;
    bus.resume     = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.rst_tb_done_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL resume_exit: got busy=%b done_valid=%b, required 0 0",
               bus.busy, bus.rst_tb_done_valid);
    end
  endtask

  task automatic test_stall();
    bit bad;
    bad = 1'b0;
    @(posedge clk);
    #1;
    bus.stall    = 1'b1;
    bus.ch_valid = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ch_ready !== '0 || bus.busy !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL stall_block: got a grant under stall, required none");
    end
    @(posedge clk);
    #1;
    push_exp(KIND_CH, 2);
    bus.stall = 1'b0;
    wait_drained("stall");
    bus.ch_valid = '0;
    wait_idle("stall");
    n_checks++;
    if (bus.sel !== 2'd2) begin
      n_fail++;
      $display("FAIL stall_sel: got %0d, required 2", bus.sel);
    end
  endtask

  task automatic test_mid_reset();
    int k;
    bit saw_done;
    bus.resume     = 1'b1;
    bus.done_ready = 1'b0;
    @(posedge clk);
    #1;
    push_exp(KIND_CH, 0);
    bus.ch_valid = 4'b0001;
    k = 0;
    @(negedge clk);
    while (!bus.rd_mem_en && k < 20) begin
      @(negedge clk);
      k++;
    end
    bus.ch_valid = '0;
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.rd_mem_en, bus.rst_tb_done_valid, bus.sel} !== 5'b0) begin
      n_fail++;
      $display("FAIL midrst_async: got busy=%b rd_mem=%b done=%b sel=%0d, required all 0",
               bus.busy, bus.rd_mem_en, bus.rst_tb_done_valid, bus.sel);
    end
    @(negedge clk);
    rst      = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rst_tb_done_valid || bus.busy) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL midrst_abort: got activity after reset, required idle");
    end
    bus.resume = 1'b0;
    @(posedge clk);
    #1;
    push_exp(KIND_CH, 0);
    bus.ch_valid = 4'hf;
    wait_drained("midrst");
    bus.ch_valid = '0;
    wait_idle("midrst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_priority();
    test_rd_latency();
    test_done_at_timeout();
    test_timeout();
    test_resume();
    test_stall();
    test_mid_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: %0d grants outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
